// File: rtl/mandelbrot_pixel_sink.sv
// Pixel sink for the mandelbrot generator: issues run strobes, packs two 4-bit pixels per byte
// into a FWFT byte FIFO. Define MANDELBROT_SINK_CHECKSUM_EN to append an XOR checksum byte per frame.
module mandelbrot_pixel_sink #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  output logic       gen_run,
  input  logic       gen_running,
  input  logic [3:0] gen_ctr_out,
  input  logic       gen_finished,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       busy,
  output logic       error
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int PIX_W = (NPIX > 2) ? $clog2(NPIX) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_CAPTURE,
`ifdef MANDELBROT_SINK_CHECKSUM_EN
    S_FLUSH,
`endif
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PIX_W-1:0] r_pix;
  logic [3:0]       r_nibble;
  logic             r_error;

  logic [7:0]       r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_sof;
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;

  logic             w_has_space;
  logic             w_push;
  logic             w_pop;
  logic             w_wr_en;
  logic [7:0]       w_push_data;
  logic             w_push_sof;
  logic             w_latch;
  logic             w_pix_inc;
  logic             w_pix_clr;
  logic             w_set_err;

`ifdef MANDELBROT_SINK_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  assign w_has_space = (r_count < DEPTH_C);
  assign w_pop       = out_valid & out_ready;
  assign w_wr_en     = w_push & (w_has_space | w_pop);

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem_data[r_rd];
  assign out_sof   = out_valid & r_mem_sof[r_rd];
  assign busy      = (r_state != S_IDLE);
  assign error     = r_error;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    gen_run     = 1'b0;
    w_push      = 1'b0;
    w_push_data = {gen_ctr_out, r_nibble};
    w_push_sof  = (r_pix == PIX_W'(1));
    w_latch     = 1'b0;
    w_pix_inc   = 1'b0;
    w_pix_clr   = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next    = S_ISSUE;
          w_pix_clr = 1'b1;
        end
      end
      S_ISSUE: begin
        // Reserving a slot here means the push at CAPTURE can never overflow.
        if (w_has_space) begin
          gen_run = 1'b1;
          w_next  = S_ARM;
        end
      end
      S_ARM: begin
        if (gen_running) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (!gen_running) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_pix_inc = 1'b1;
        if (r_pix[0]) w_push = 1'b1;
        else          w_latch = 1'b1;
        if (gen_finished || (r_pix == LAST_PIX)) begin
          w_set_err = !(gen_finished && (r_pix == LAST_PIX));
`ifdef MANDELBROT_SINK_CHECKSUM_EN
          w_next = S_FLUSH;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_ISSUE;
        end
      end
`ifdef MANDELBROT_SINK_CHECKSUM_EN
      S_FLUSH: begin
        w_push_data = r_csum;
        w_push_sof  = 1'b0;
        if (w_has_space) begin
          w_push = 1'b1;
          w_next = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (continuous) begin
          w_next    = S_ISSUE;
          w_pix_clr = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pix    <= '0;
      r_nibble <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pix_clr)      r_pix <= '0;
      else if (w_pix_inc) r_pix <= r_pix + 1'b1;
      if (w_latch)   r_nibble <= gen_ctr_out;
      if (w_set_err) r_error  <= 1'b1;
    end
  end

`ifdef MANDELBROT_SINK_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_pix_clr) begin
      r_csum <= '0;
    end else if (w_wr_en && (r_state == S_CAPTURE)) begin
      r_csum <= r_csum ^ w_push_data;
    end
  end
`endif

  // NOTE: the FIFO storage is reset (only a few flops) so out_data reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem_data[i] <= '0;
      r_mem_sof <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem_data[r_wr] <= w_push_data;
        r_mem_sof[r_wr]  <= w_push_sof;
        r_wr             <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
// Self-checking bench for mandelbrot_pixel_sink: behavioural generator, byte-stream expectations
// derived from pixel values, directed phases with randomized latency and backpressure.
module tb_mandelbrot_pixel_sink;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       out_ready = 1'b0;
  logic       gen_running;
  logic [3:0] gen_ctr_out;
  logic       gen_finished;
  logic       gen_run;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sof;
  logic       busy;
  logic       error;

  int errors = 0;
  int checks = 0;

  logic [3:0] vals [8];
  int         fin_at = 8;

  int         runs = 0;
  int         dbl_runs = 0;
  logic       prev_run = 1'b0;
  logic [8:0] obs_q [$];
  logic [8:0] exp_q [$];
  int         obs_base;
  int         run_base;

  mandelbrot_pixel_sink #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .continuous   (continuous),
    .gen_run      (gen_run),
    .gen_running  (gen_running),
    .gen_ctr_out  (gen_ctr_out),
    .gen_finished (gen_finished),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sof      (out_sof),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Generator model: pixel numbering restarts after a finished pixel; busy for a random 2..5 cycles.
  int g_pix;
  int g_rem;
  always @(posedge clk or negedge rst_n) begin : gen_model
    int nxt;
    if (!rst_n) begin
      gen_running  <= 1'b0;
      gen_ctr_out  <= 4'h0;
      gen_finished <= 1'b0;
      g_pix        <= 0;
      g_rem        <= 0;
    end else if (gen_run) begin
      nxt = gen_finished ? 1 : g_pix + 1;
      g_pix        <= nxt;
      gen_ctr_out  <= vals[(nxt - 1) & 7];
      gen_finished <= (nxt == fin_at);
      gen_running  <= 1'b1;
      g_rem        <= int'($urandom_range(2, 5));
    end else if (gen_running) begin
      if (g_rem <= 1) gen_running <= 1'b0;
      else            g_rem <= g_rem - 1;
    end
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) obs_q.push_back({out_sof, out_data});
    if (gen_run) runs <= runs + 1;
    if (gen_run && prev_run) dbl_runs <= dbl_runs + 1;
    prev_run <= gen_run;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream for a frame of npix captured pixels, low nibble = earlier pixel.
  task automatic expect_frame(input int npix);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i + 1 < npix; i += 2) begin
      b = {vals[i+1], vals[i]};
      exp_q.push_back({(i == 0), b});
      cs = cs ^ b;
    end
`ifdef MANDELBROT_SINK_CHECKSUM_EN
    exp_q.push_back({1'b0, cs});
`endif
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_nbytes"}, obs_q.size() - obs_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), obs_q[obs_base + i], exp_q[i]);
  endtask

  task automatic begin_phase();
    exp_q.delete();
    obs_base = obs_q.size();
    run_base = runs;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit rnd_ready);
    int n;
    n = 0;
    while ((busy || out_valid) && n < 3000) begin
      cycle();
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check({tag, "_idle"}, {busy, out_valid}, 2'b00);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 8; i++) vals[i] = 4'(i + 1);
  endtask

  initial begin
    set_ramp();
    #2;
    check("rst_gen_run", gen_run, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sof", out_sof, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // Basic frame, no backpressure.
    begin_phase();
    out_ready = 1'b1;
    fin_at = 8;
    expect_frame(8);
    pulse_start();
    wait_idle("basic", 1'b0);
    check("basic_runs", runs - run_base, 8);
    check("basic_error", error, 1'b0);
    check_bytes("basic");

    // Backpressure with continuous frames: sink parks once four bytes are buffered.
    begin_phase();
    out_ready = 1'b0;
    continuous = 1'b1;
    expect_frame(8);
    expect_frame(8);
    pulse_start();
    repeat (300) cycle();
    check("bp_runs_parked", runs - run_base, 8);
    check("bp_busy", busy, 1'b1);
    check("bp_valid", out_valid, 1'b1);
    check("bp_head", {out_sof, out_data}, 9'h121);
    repeat (40) cycle();
    check("bp_runs_still", runs - run_base, 8);
    begin
      int n;
      n = 0;
      while (runs - run_base <= 8 && n < 3000) begin
        cycle();
        out_ready = 1'($urandom_range(0, 1));
        n++;
      end
    end
    check("bp_resumed", (runs - run_base > 8), 1'b1);
    continuous = 1'b0;
    wait_idle("bp", 1'b1);
    check("bp_runs_total", runs - run_base, 16);
    check_bytes("bp");

    // Short frame: finished on pixel 6 sets the sticky error.
    begin_phase();
    out_ready = 1'b1;
    fin_at = 6;
    expect_frame(6);
    pulse_start();
    wait_idle("short", 1'b0);
    check("short_error", error, 1'b1);
    check("short_runs", runs - run_base, 6);
    check_bytes("short");

    // Random pixel values, random backpressure, a start pulse while busy is ignored.
    begin_phase();
    fin_at = 8;
    for (int i = 0; i < 8; i++) vals[i] = 4'($urandom_range(0, 15));
    expect_frame(8);
    pulse_start();
    repeat (15) begin
      cycle();
      out_ready = 1'($urandom_range(0, 1));
    end
    check("rnd_busy_before_restart", busy, 1'b1);
    pulse_start();
    wait_idle("rnd", 1'b1);
    check("rnd_runs", runs - run_base, 8);
    check("rnd_error_sticky", error, 1'b1);
    check_bytes("rnd");

    // Reset while waiting on the generator with two bytes queued.
    begin_phase();
    set_ramp();
    out_ready = 1'b0;
    pulse_start();
    begin
      int n;
      n = 0;
      while (runs - run_base < 5 && n < 2000) begin
        cycle();
        n++;
      end
    end
    check("mid_runs", runs - run_base, 5);
    cycle();
    check("mid_in_wait", {busy, gen_running, gen_run}, 3'b110);
    check("mid_head", {out_valid, out_sof, out_data}, 10'h321);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_run", gen_run, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    check("mid_after_busy", busy, 1'b0);
    check("mid_after_valid", out_valid, 1'b0);
    check("mid_after_error", error, 1'b0);
    check("mid_no_bytes", obs_q.size() - obs_base, 0);

    // Clean frame after reset.
    begin_phase();
    out_ready = 1'b1;
    expect_frame(8);
    pulse_start();
    wait_idle("post", 1'b0);
    check("post_runs", runs - run_base, 8);
    check("post_error", error, 1'b0);
    check_bytes("post");

    check("run_width", dbl_runs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
